arb_mux_n: RTL

ARB_MUX_N -- requirements
Module: arb_mux_n

---
 rtl/arb_pkg.sv | 12 +
 rtl/arb_grant.sv | 42 ++++
 rtl/arb_mux_n.sv | 89 ++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared constants and helpers for the N-way arbitrating output mux.
package arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Select-index width; a single channel still needs one bit for out_sel.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_grant.sv
// Combinational rotating priority encoder: first request at or after the start
// pointer (wrapping) wins; fixed mode always starts the search at channel 0.
module arb_grant #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_ptr,
  input  logic             i_mode,
  output logic [N-1:0]     o_grant,
  output logic [SEL_W-1:0] o_idx,
  output logic             o_any
);

  localparam logic [SEL_W:0] L_N = (SEL_W+1)'(N);

  logic [SEL_W-1:0] w_start;
  logic [SEL_W-1:0] w_off;
  logic [N-1:0]     w_rot;
  logic [SEL_W:0]   w_sum;

  assign w_start = i_mode ? i_ptr : '0;

  // Rotating the doubled vector puts the start channel at bit 0.
  assign w_rot = N'({i_req, i_req} >> w_start);

  always_comb begin
    w_off = '0;
    o_any = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (w_rot[j]) begin
        w_off = SEL_W'(j);
        o_any = 1'b1;
      end
    end
  end

  assign w_sum   = {1'b0, w_start} + {1'b0, w_off};
  assign o_idx   = (w_sum >= L_N) ? SEL_W'(w_sum - L_N) : w_sum[SEL_W-1:0];
  assign o_grant = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/arb_mux_n.sv
// N-channel arbiter feeding a single output register with valid/ready handshakes
// on both sides; sustains one word per cycle when downstream is always ready.
module arb_mux_n
  import arb_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int RR    = ARB_RR
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N-1:0]            in_valid,
  input  logic [N*WIDTH-1:0]      in_data,
  output logic [N-1:0]            in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [sel_width(N)-1:0] out_sel,
  input  logic                    out_ready
);

  localparam int   SEL_W = sel_width(N);
  localparam logic IS_RR = (RR == ARB_RR);

  logic [SEL_W-1:0] r_ptr;
  logic             r_outValid;
  logic [WIDTH-1:0] r_outData;
  logic [SEL_W-1:0] r_outSel;

  logic [N-1:0]     w_grant;
  logic [SEL_W-1:0] w_idx;
  logic             w_any;
  logic             w_free;
  logic             w_accept;
  logic [WIDTH-1:0] w_data;
  logic [SEL_W-1:0] w_ptrNext;

  arb_grant #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_grant (
    .i_req   (in_valid),
    .i_ptr   (r_ptr),
    .i_mode  (IS_RR),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Gating with reset_n keeps in_ready low for the whole reset window.
  assign w_free   = ~r_outValid | out_ready;
  assign w_accept = reset_n & w_free & w_any;
  assign in_ready = w_accept ? w_grant : '0;

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ptrNext = (w_idx == SEL_W'(N - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr      <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outSel   <= '0;
    end else begin
      if (w_accept) begin
        r_outValid <= 1'b1;
        r_outData  <= w_data;
        r_outSel   <= w_idx;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end
      if (IS_RR && w_accept) begin
        r_ptr <= w_ptrNext;
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_sel   = r_outSel;

endmodule
